// File: rtl/j6502_bus_pkg.sv
// Shared definitions for the j6502 bus controller: FSM encoding, open-bus value
// and the region-count limit.
package j6502_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_HOLD   = 2'd3
  } bus_state_t;

  localparam logic [7:0] OPEN_BUS    = 8'hFF;
  localparam int         MAX_REGIONS = 8;
  localparam int         IDX_W       = 3;

endpackage

// File: rtl/j6502_addr_decode.sv
// Combinational priority decoder: maps a CPU address onto the chip-select
// region table; the lowest matching region index wins.
module j6502_addr_decode
  import j6502_bus_pkg::*;
#(
  parameter int NUM_REGIONS = 4
) (
  input  logic [15:0]               address,
  input  logic [16*NUM_REGIONS-1:0] region_base,
  input  logic [16*NUM_REGIONS-1:0] region_mask,
  output logic                      hit,
  output logic [NUM_REGIONS-1:0]    onehot,
  output logic [IDX_W-1:0]          index
);

  // Scan from the top down so the lowest matching index is the last writer.
  always_comb begin
    hit    = 1'b0;
    onehot = '0;
    index  = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if ((address & region_mask[16*i +: 16]) == region_base[16*i +: 16]) begin
        hit       = 1'b1;
        onehot    = '0;
        onehot[i] = 1'b1;
        index     = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/j6502_bus_ctrl.sv
// 6502 bus controller: decodes phi2 cycles onto chip-select regions with
// per-region wait states. Define J6502_BUS_ERR_EN to enable the bus_err pulse.
module j6502_bus_ctrl
  import j6502_bus_pkg::*;
#(
  parameter int NUM_REGIONS = 4,
  parameter int WAIT_W      = 3
) (
  input  logic                          fst_clk,
  input  logic                          res_n,
  input  logic                          phi2,
  input  logic [15:0]                   address,
  input  logic                          rw_n,
  input  logic [7:0]                    data_out,
  input  logic [16*NUM_REGIONS-1:0]     region_base,
  input  logic [16*NUM_REGIONS-1:0]     region_mask,
  input  logic [WAIT_W*NUM_REGIONS-1:0] region_wait,
  input  logic [8*NUM_REGIONS-1:0]      dev_rdata,
  output logic [NUM_REGIONS-1:0]        cs_n,
  output logic                          dev_rd,
  output logic                          dev_wr,
  output logic [7:0]                    dev_wdata,
  output logic [7:0]                    data_in,
  output logic                          rdy,
  output logic                          bus_err
);

  bus_state_t               state, state_nxt;
  logic                     phi2_q;
  logic                     phi2_rise;
  logic [WAIT_W-1:0]        cnt;
  logic                     rw_q;
  logic [NUM_REGIONS-1:0]   sel_q;
  logic                     dec_hit;
  logic [NUM_REGIONS-1:0]   dec_onehot;
  logic [IDX_W-1:0]         dec_idx;
  logic [WAIT_W-1:0]        dec_wait;
  logic [7:0]               rd_sel;

  assign phi2_rise = phi2 & ~phi2_q;

  j6502_addr_decode #(.NUM_REGIONS(NUM_REGIONS)) u_decode (
    .address     (address),
    .region_base (region_base),
    .region_mask (region_mask),
    .hit         (dec_hit),
    .onehot      (dec_onehot),
    .index       (dec_idx)
  );

  always_comb begin
    dec_wait = '0;
    rd_sel   = OPEN_BUS;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (dec_onehot[i]) dec_wait = region_wait[WAIT_W*i +: WAIT_W];
      if (sel_q[i])      rd_sel   = dev_rdata[8*i +: 8];
    end
  end

  always_ff @(posedge fst_clk or negedge res_n) begin
    if (!res_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (phi2_rise) begin
                   if (!dec_hit)           state_nxt = ST_HOLD;
                   else if (dec_wait == '0) state_nxt = ST_ACCESS;
                   else                    state_nxt = ST_WAIT;
                 end
      ST_WAIT:   if (cnt == WAIT_W'(1)) state_nxt = ST_ACCESS;
      ST_ACCESS: state_nxt = ST_HOLD;
      ST_HOLD:   if (!phi2) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // phi2_q resets high so a phi2 already high at reset release is not a rise.
  always_ff @(posedge fst_clk or negedge res_n) begin
    if (!res_n) begin
      phi2_q    <= 1'b1;
      cnt       <= '0;
      rw_q      <= 1'b1;
      sel_q     <= '0;
      data_in   <= OPEN_BUS;
      dev_wdata <= 8'h00;
    end else begin
      phi2_q <= phi2;
      case (state)
        ST_IDLE: if (phi2_rise) begin
          sel_q     <= dec_onehot;
          rw_q      <= rw_n;
          dev_wdata <= data_out;
          cnt       <= dec_wait;
          if (!dec_hit) data_in <= OPEN_BUS;
        end
        ST_WAIT:   cnt <= cnt - WAIT_W'(1);
        ST_ACCESS: if (rw_q) data_in <= rd_sel;
        ST_HOLD:   if (!phi2) begin
          sel_q     <= '0;
          dev_wdata <= 8'h00;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rdy    = (state != ST_WAIT);
    dev_rd = (state == ST_ACCESS) &&  rw_q;
    dev_wr = (state == ST_ACCESS) && !rw_q;
    cs_n   = (state != ST_IDLE) ? ~sel_q : '1;
  end

`ifdef J6502_BUS_ERR_EN
  always_ff @(posedge fst_clk or negedge res_n) begin
    if (!res_n) bus_err <= 1'b0;
    else        bus_err <= (state == ST_IDLE) && phi2_rise && !dec_hit;
  end
`else
  assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_j6502_bus_ctrl.sv
// Scoreboard bench for j6502_bus_ctrl: directed bus cycles push expectations,
// a negedge monitor checks every device access the controller presents.
module tb_j6502_bus_ctrl;

  localparam int NR = 4;
  localparam int WW = 3;
`ifdef J6502_BUS_ERR_EN
  localparam int EXP_BERR = 1;
`else
  localparam int EXP_BERR = 0;
`endif

  logic           clk = 1'b0;
  logic           res_n = 1'b0;
  logic           phi2 = 1'b0;
  logic [15:0]    address = 16'h0000;
  logic           rw_n = 1'b1;
  logic [7:0]     data_out = 8'h00;
  logic [16*NR-1:0] region_base;
  logic [16*NR-1:0] region_mask;
  logic [WW*NR-1:0] region_wait;
  logic [8*NR-1:0]  dev_rdata;
  logic [NR-1:0]  cs_n;
  logic           dev_rd, dev_wr, rdy, bus_err;
  logic [7:0]     dev_wdata, data_in;

  j6502_bus_ctrl #(.NUM_REGIONS(NR), .WAIT_W(WW)) dut (
    .fst_clk(clk), .res_n(res_n), .phi2(phi2), .address(address), .rw_n(rw_n),
    .data_out(data_out), .region_base(region_base), .region_mask(region_mask),
    .region_wait(region_wait), .dev_rdata(dev_rdata), .cs_n(cs_n),
    .dev_rd(dev_rd), .dev_wr(dev_wr), .dev_wdata(dev_wdata), .data_in(data_in),
    .rdy(rdy), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NR-1:0] cs;
    bit            wr;
    logic [7:0]    wd;
    logic [7:0]    rd;
    int            nw;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   checks = 0;
  int   failures = 0;
  int   wcnt = 0;
  bit   pend = 0;
  int   access_seen = 0;
  int   cs_low_cnt = 0;
  int   berr_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: consumes one expectation per observed dev_rd/dev_wr pulse.
  always @(negedge clk) begin
    if (!res_n) begin
      wcnt = 0;
      pend = 0;
    end else begin
      if (cs_n != '1) cs_low_cnt++;
      if (bus_err) berr_cnt++;
      if (pend) begin
        pend = 0;
        check("pulse_one_cycle", {31'd0, dev_rd | dev_wr}, 32'd0);
        if (!cur.wr) check("data_in", {24'd0, data_in}, {24'd0, cur.rd});
      end
      if (dev_rd || dev_wr) begin
        access_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_access", 32'd1, 32'd0);
        end else begin
          cur = exp_q.pop_front();
          check("cs_n", {28'd0, cs_n}, {28'd0, cur.cs});
          check("direction", {30'd0, dev_wr, dev_rd}, cur.wr ? 32'd2 : 32'd1);
          check("wait_cycles", wcnt, cur.nw);
          if (cur.wr) check("dev_wdata", {24'd0, dev_wdata}, {24'd0, cur.wd});
          pend = 1;
        end
        wcnt = 0;
      end else if (!rdy) begin
        wcnt++;
      end
    end
  end

  task automatic set_region(input int i, input logic [15:0] b, input logic [15:0] m,
                            input logic [WW-1:0] w);
    region_base[16*i +: 16] = b;
    region_mask[16*i +: 16] = m;
    region_wait[WW*i +: WW] = w;
  endtask

  task automatic do_cycle(input logic [15:0] a, input logic rw, input logic [7:0] wd,
                          input int hi);
    @(posedge clk); #1;
    address = a; rw_n = rw; data_out = wd; phi2 = 1'b1;
    repeat (hi) @(posedge clk);
    #1 phi2 = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic do_access(input logic [15:0] a, input logic rw, input logic [7:0] wd,
                           input logic [NR-1:0] cs, input logic [7:0] rd, input int nw);
    exp_t e;
    e.cs = cs; e.wr = !rw; e.wd = wd; e.rd = rd; e.nw = nw;
    exp_q.push_back(e);
    do_cycle(a, rw, wd, 10);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cs_n"},      {28'd0, cs_n}, 32'hF);
    check({tag, "_dev_rd"},    {31'd0, dev_rd}, 32'd0);
    check({tag, "_dev_wr"},    {31'd0, dev_wr}, 32'd0);
    check({tag, "_rdy"},       {31'd0, rdy}, 32'd1);
    check({tag, "_data_in"},   {24'd0, data_in}, 32'hFF);
    check({tag, "_dev_wdata"}, {24'd0, dev_wdata}, 32'h00);
    check({tag, "_bus_err"},   {31'd0, bus_err}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cs0, be0, acc0;
    region_base = '0; region_mask = '0; region_wait = '0;
    set_region(0, 16'h0000, 16'h8000, 3'd0);
    set_region(1, 16'h8000, 16'hE000, 3'd1);
    set_region(2, 16'hC000, 16'hC000, 3'd3);
    set_region(3, 16'h9000, 16'hF000, 3'd2);
    dev_rdata = {8'hD3, 8'hC2, 8'hA1, 8'h5A};

    repeat (3) @(posedge clk);
    #1 check_reset_vals("reset");
    res_n = 1'b1;
    repeat (2) @(posedge clk);

    do_access(16'h1234, 1'b1, 8'h00, 4'b1110, 8'h5A, 0);
    do_access(16'hC010, 1'b0, 8'h77, 4'b1011, 8'h00, 3);
    do_access(16'h9000, 1'b1, 8'h00, 4'b1101, 8'hA1, 1);

    set_region(0, 16'h0000, 16'hC000, 3'd0);
    cs0 = cs_low_cnt; be0 = berr_cnt; acc0 = access_seen;
    do_cycle(16'h7FFF, 1'b1, 8'h00, 10);
    check("miss_cs_n", cs_low_cnt - cs0, 0);
    check("miss_access", access_seen - acc0, 0);
    check("miss_bus_err", berr_cnt - be0, EXP_BERR);
    check("miss_data_in", {24'd0, data_in}, 32'hFF);

    set_region(1, 16'h8000, 16'hE000, 3'd5);
    acc0 = access_seen;
    @(posedge clk); #1;
    address = 16'h9000; rw_n = 1'b1; data_out = 8'h33; phi2 = 1'b1;
    repeat (3) @(posedge clk);
    #3 check("pre_reset_rdy", {31'd0, rdy}, 32'd0);
    res_n = 1'b0;
    #1 check_reset_vals("midwait");
    repeat (2) @(posedge clk);
    #3 res_n = 1'b1;
    repeat (8) @(posedge clk);
    #1 phi2 = 1'b0;
    repeat (4) @(posedge clk);
    check("post_reset_access", access_seen - acc0, 0);

    do_access(16'h9000, 1'b1, 8'h00, 4'b1101, 8'hA1, 5);
    set_region(1, 16'h8000, 16'hE000, 3'd7);
    do_access(16'h8ABC, 1'b1, 8'h00, 4'b1101, 8'hA1, 7);
    do_access(16'hFFFF, 1'b0, 8'hE5, 4'b1011, 8'h00, 3);

    repeat (5) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
